// File: rtl/arb_and_or_mux.sv
// Round-robin N:1 stream arbiter with one-hot AND-OR payload select feeding a 2-entry output FIFO.
// Define ARB_AND_OR_MUX_LOCK_EN to hold the grant on one channel until its in_last beat is accepted.
module arb_and_or_mux #(
  parameter int INPUTS     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [INPUTS-1:0]            in_valid,
  input  logic [INPUTS-1:0]            in_last,
  output logic [INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INPUTS-1:0]            grant
);

  localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  logic [PTR_W-1:0]      r_ptr;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic                  r_head_last;
  logic                  r_tail_last;
  logic                  r_hold;
  logic [INPUTS-1:0]     r_hold_grant;
`ifdef ARB_AND_OR_MUX_LOCK_EN
  logic                  r_lock;
  logic [INPUTS-1:0]     r_lock_grant;
`endif

  logic [INPUTS-1:0]     w_rr_grant;
  logic [INPUTS-1:0]     w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic                  w_space;
  logic                  w_push;
  logic                  w_pop;

  // First valid channel at or above the pointer wins, else the first valid one below it.
  function automatic logic [INPUTS-1:0] rr_pick(input logic [INPUTS-1:0] valid,
                                               input logic [PTR_W-1:0]  ptr);
    logic [INPUTS-1:0] pick;
    logic              found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (!found && valid[i] && (PTR_W'(i) >= ptr)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < INPUTS; i++) begin
      if (!found && valid[i] && (PTR_W'(i) < ptr)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

  // Grant selection: reset gate, packet lock, stall hold, then fresh round-robin.
  always_comb begin
    w_rr_grant = rr_pick(in_valid, r_ptr);
    if (rst) begin
      w_grant = '0;
    end
`ifdef ARB_AND_OR_MUX_LOCK_EN
    else if (r_lock) begin
      w_grant = r_lock_grant;
    end
`endif
    else if (r_hold && |(r_hold_grant & in_valid)) begin
      w_grant = r_hold_grant;
    end else begin
      w_grant = w_rr_grant;
    end
  end

  // One-hot AND-OR payload select and grant index encode.
  always_comb begin
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < INPUTS; i++) begin
      w_sel_data  = w_sel_data | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
      w_sel_last  = w_sel_last | (in_last[i] & w_grant[i]);
      w_grant_idx = w_grant_idx | (w_grant[i] ? PTR_W'(i) : '0);
    end
  end

  // in_ready depends only on grant and registered occupancy, never on out_ready.
  assign w_space  = (r_count != 2'd2);
  assign in_ready = w_grant & {INPUTS{w_space}};
  assign w_push   = |(in_ready & in_valid);
  assign w_pop    = out_valid & out_ready;

  // Arbitration state: pointer, stall hold and optional packet lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_hold       <= 1'b0;
      r_hold_grant <= '0;
`ifdef ARB_AND_OR_MUX_LOCK_EN
      r_lock       <= 1'b0;
      r_lock_grant <= '0;
`endif
    end else begin
      if (w_push) begin
        r_ptr <= (w_grant_idx == PTR_W'(INPUTS - 1)) ? '0 : (w_grant_idx + PTR_W'(1));
      end
      r_hold       <= |(w_grant & in_valid) & ~w_space;
      r_hold_grant <= w_grant;
`ifdef ARB_AND_OR_MUX_LOCK_EN
      if (w_push) begin
        r_lock       <= ~w_sel_last;
        r_lock_grant <= w_grant;
      end
`endif
    end
  end

  // Two-entry FIFO; push and pop together only happen at count 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_data <= w_sel_data;
            r_head_last <= w_sel_last;
          end else begin
            r_tail_data <= w_sel_data;
            r_tail_last <= w_sel_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_data <= r_tail_data;
          r_head_last <= r_tail_last;
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          r_head_data <= w_sel_data;
          r_head_last <= w_sel_last;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data  = r_head_data;
  assign out_last  = r_head_last;
  assign out_valid = (r_count != 2'd0);
  assign grant     = w_grant;

endmodule

// File: tb/tb_arb_and_or_mux.sv
// Scoreboard bench for arb_and_or_mux: a 4-input/16-bit instance plus a 3-input/8-bit instance.
module tb_arb_and_or_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] d [4];
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  grant;

  logic [23:0] in3_data;
  logic [2:0]  in3_valid;
  logic [2:0]  in3_last;
  logic [2:0]  in3_ready;
  logic [7:0]  out3_data;
  logic        out3_last;
  logic        out3_valid;
  logic        out3_ready;
  logic [2:0]  grant3;

  assign in_data = {d[3], d[2], d[1], d[0]};

  arb_and_or_mux #(.INPUTS(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant)
  );

  arb_and_or_mux #(.INPUTS(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in3_data), .in_valid(in3_valid), .in_last(in3_last),
    .in_ready(in3_ready), .out_data(out3_data), .out_last(out3_last), .out_valid(out3_valid),
    .out_ready(out3_ready), .grant(grant3)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] sb [$];
  logic [16:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 4'b0000;
    tick();
    rst      = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the output handshake will complete on the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got 0x%0h, expected no beat", {out_last, out_data});
      end else begin
        mon_exp = sb.pop_front();
        chk("out_beat", {15'd0, out_last, out_data}, {15'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int n0;
    int n1;
    int n0_max;
    logic f0;
    logic f1;

    rst        = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 4'b1111;
    in_last    = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 16'h1000 + 16'(i);
    in3_data   = {8'hC2, 8'hB1, 8'hA0};
    in3_valid  = 3'b000;
    in3_last   = 3'b111;
    out3_ready = 1'b1;

    // Reset state, with all channels requesting during reset.
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);

    // Full round robin, one beat per cycle, 1-cycle latency.
    sb.push_back({1'b1, 16'h1000});
    sb.push_back({1'b1, 16'h1001});
    sb.push_back({1'b1, 16'h1002});
    sb.push_back({1'b1, 16'h1003});
    sb.push_back({1'b1, 16'h1000});
    rst = 1'b0;
    tick();
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_data", {16'd0, out_data}, 32'h1000);
    for (int c = 1; c < 5; c++) tick();
    in_valid = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
    chk("rr_drained", sb.size(), 32'd0);

    // Single channel into a stalled output: FIFO fills at two and holds.
    do_reset();
    out_ready = 1'b0;
    d[2]      = 16'h2000;
    in_valid  = 4'b0100;
    sb.push_back({1'b1, 16'h2000});
    sb.push_back({1'b1, 16'h2001});
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_in_ready2", {31'd0, in_ready[2]}, (c < 2) ? 32'd1 : 32'd0);
      f0 = in_valid[2] & in_ready[2];
      tick();
      if (f0) d[2] = d[2] + 16'd1;
      chk("stall_hold_data", {16'd0, out_data}, 32'h2000);
      chk("stall_grant", {28'd0, grant}, 32'h4);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("stall_drained", sb.size(), 32'd0);

    // Channel 1 three-beat packet against a competing channel 0.
    do_reset();
    out_ready = 1'b1;
    n0 = 0;
    n1 = 0;
`ifdef ARB_AND_OR_MUX_LOCK_EN
    n0_max = 1;
    sb.push_back({1'b0, 16'h1100});
    sb.push_back({1'b0, 16'h1101});
    sb.push_back({1'b1, 16'h1102});
    sb.push_back({1'b1, 16'h0A00});
`else
    n0_max = 2;
    sb.push_back({1'b0, 16'h1100});
    sb.push_back({1'b1, 16'h0A00});
    sb.push_back({1'b0, 16'h1101});
    sb.push_back({1'b1, 16'h0A01});
    sb.push_back({1'b1, 16'h1102});
`endif
    for (int cyc = 0; cyc < 20 && !(n1 == 3 && n0 == n0_max); cyc++) begin
      in_valid = {2'b00, (n1 < 3), (cyc >= 1 && n0 < n0_max)};
      in_last  = {2'b11, (n1 == 2), 1'b1};
      d[0]     = 16'h0A00 + 16'(n0);
      d[1]     = 16'h1100 + 16'(n1);
      #1;
`ifdef ARB_AND_OR_MUX_LOCK_EN
      if (n1 == 1 || n1 == 2) chk("lock_blocks_ch0", {31'd0, in_ready[0]}, 32'd0);
`endif
      f0 = in_valid[0] & in_ready[0];
      f1 = in_valid[1] & in_ready[1];
      tick();
      n0 = n0 + int'(f0);
      n1 = n1 + int'(f1);
    end
    in_valid = 4'b0000;
    in_last  = 4'b1111;
    chk("pkt_ch1_beats", n1, 32'd3);
    chk("pkt_ch0_beats", n0, n0_max);
    for (int c = 0; c < 3; c++) tick();
    chk("pkt_drained", sb.size(), 32'd0);

    // Reset while FIFO full and (if enabled) a packet lock is open.
    do_reset();
    out_ready = 1'b0;
    in_last   = 4'b0000;
    d[1]      = 16'h3300;
    in_valid  = 4'b0010;
    for (int c = 0; c < 3; c++) tick();
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {28'd0, in_ready}, 32'd0);
    chk("full_grant", {28'd0, grant}, 32'h2);
    rst      = 1'b1;
    in_valid = 4'b1011;
    in_last  = 4'b1111;
    d[0]     = 16'h0B00;
    d[3]     = 16'h3B00;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    chk("midrst_in_ready", {28'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_grant_ch0", {28'd0, grant}, 32'h1);
    sb.push_back({1'b1, 16'h0B00});
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
    chk("midrst_drained", sb.size(), 32'd0);

    // Three-input instance: channels 0 and 2 alternate, pointer wraps 2 -> 0.
    in3_valid = 3'b101;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr3_grant", {29'd0, grant3}, (k % 2 == 0) ? 32'h1 : 32'h4);
      chk("rr3_in_ready", {29'd0, in3_ready}, (k % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      chk("rr3_out_data", {24'd0, out3_data}, (k % 2 == 0) ? 32'hA0 : 32'hC2);
      chk("rr3_out_ctl", {30'd0, out3_valid, out3_last}, 32'h3);
    end
    in3_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
